mul_logic_pipe: RTL and testbench



---
 rtl/mul_logic_pkg.sv | 14 +
 rtl/mul_logic_stage.sv | 24 ++
 rtl/mul_logic_pipe.sv | 92 +++++++++
 tb/tb_mul_logic_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_logic_pkg.sv
// Shared definitions for the pipelined multiply-then-bitwise unit.
package mul_logic_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned MAX_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

endpackage

// File: rtl/mul_logic_stage.sv
// One pipeline slot: valid bit plus data, loaded under a shared enable.
module mul_logic_stage #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          d_valid,
  input  logic [DW-1:0] d,
  output logic          q_valid,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q       <= d;
    end
  end

endmodule

// File: rtl/mul_logic_pipe.sv
// Pipelined (a*b) op c with valid/ready handshake; DEPTH register stages,
// global advance enable, result forced to zero while not valid.
module mul_logic_pipe
  import mul_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "mul_logic_pipe: WIDTH out of range");
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "mul_logic_pipe: DEPTH out of range");
  end

  localparam int unsigned S1W = 2 * WIDTH + 2;

  logic             adv;
  logic [WIDTH-1:0] prod;
  logic [S1W-1:0]   s1_d;
  logic [WIDTH-1:0] s1_prod;
  logic [WIDTH-1:0] s1_c;
  op_e              s1_op;
  logic [WIDTH-1:0] comb_res;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ~rst;

  // Multiplying in a WIDTH-bit context keeps exactly the low half of the product.
  assign prod = a * b;

  assign s1_prod = s1_d[S1W-1 -: WIDTH];
  assign s1_c    = s1_d[WIDTH+1 -: WIDTH];
  assign s1_op   = op_e'(s1_d[1:0]);

  always_comb begin
    comb_res = s1_prod;
    case (s1_op)
      OP_AND:  comb_res = s1_prod & s1_c;
      OP_OR:   comb_res = s1_prod | s1_c;
      OP_XOR:  comb_res = s1_prod ^ s1_c;
      OP_PASS: comb_res = s1_prod;
      default: comb_res = s1_prod;
    endcase
  end

  // d[0] is the combined stage-1 value; d[i] for i>0 are delay registers.
  assign d[0] = comb_res;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      mul_logic_stage #(.DW(S1W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .d_valid (in_valid),
        .d       ({prod, c, op}),
        .q_valid (v[0]),
        .q       (s1_d)
      );
    end else begin : g_rest
      mul_logic_stage #(.DW(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .d_valid (v[i-1]),
        .d       (d[i-1]),
        .q_valid (v[i]),
        .q       (d[i])
      );
    end
  end

  assign out_valid = v[DEPTH-1];
  assign p         = out_valid ? d[DEPTH-1] : '0;

endmodule

// File: tb/tb_mul_logic_pipe.sv
// Bench for mul_logic_pipe: three configurations checked against a slot-level reference model.
module tb_mul_logic_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  iv, ordy, ov, ir;
  logic [15:0] a_s [3];
  logic [15:0] b_s [3];
  logic [15:0] c_s [3];
  logic [1:0]  op_s [3];
  logic [15:0] pw [3];
  logic [7:0]  p8;

  int dep [3] = '{2, 3, 1};
  int wid [3] = '{16, 16, 8};

  logic        mv [3][8];
  logic [15:0] md [3][8];

  int checks = 0;
  int errors = 0;

  mul_logic_pipe #(.WIDTH(16), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .op(op_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p(pw[0])
  );

  mul_logic_pipe #(.WIDTH(16), .DEPTH(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .op(op_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p(pw[1])
  );

  mul_logic_pipe #(.WIDTH(8), .DEPTH(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2][7:0]), .b(b_s[2][7:0]), .c(c_s[2][7:0]), .op(op_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .p(p8)
  );

  assign pw[2] = {8'h00, p8};

  // Result computed straight from the arithmetic rule, masked to the instance width.
  function automatic logic [15:0] ref_f(int k, logic [1:0] o, logic [15:0] x, logic [15:0] y, logic [15:0] z);
    logic [15:0] m, pr, r;
    m  = (wid[k] == 16) ? 16'hFFFF : 16'h00FF;
    pr = 16'(32'(x) * 32'(y)) & m;
    case (o)
      2'd0:    r = pr & z;
      2'd1:    r = pr | z;
      2'd2:    r = pr ^ z;
      default: r = pr;
    endcase
    return r & m;
  endfunction

  function automatic logic exp_v(int k);
    return mv[k][dep[k]-1];
  endfunction

  function automatic logic [15:0] exp_p(int k);
    return exp_v(k) ? md[k][dep[k]-1] : 16'h0000;
  endfunction

  function automatic logic exp_ir(int k);
    return ~rst & (ordy[k] | ~exp_v(k));
  endfunction

  task automatic cycle();
    logic adv [3];
    for (int k = 0; k < 3; k++) adv[k] = ordy[k] | ~exp_v(k);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int s = 0; s < 8; s++) begin
          mv[k][s] = 1'b0;
          md[k][s] = '0;
        end
      end else if (adv[k]) begin
        for (int s = dep[k] - 1; s > 0; s--) begin
          mv[k][s] = mv[k][s-1];
          md[k][s] = md[k][s-1];
        end
        mv[k][0] = iv[k];
        md[k][0] = ref_f(k, op_s[k], a_s[k], b_s[k], c_s[k]);
      end
    end
    #1;
  endtask

  task automatic idle();
    iv   = '0;
    ordy = '1;
    rst  = 1'b0;
  endtask

  task automatic drive(int k, logic [15:0] x, logic [15:0] y, logic [15:0] z, logic [1:0] o);
    iv[k]   = 1'b1;
    a_s[k]  = x;
    b_s[k]  = y;
    c_s[k]  = z;
    op_s[k] = o;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 8; s++) begin
        mv[k][s] = 1'b0;
        md[k][s] = '0;
      end
      drive(k, 16'(k + 3), 16'h0005, 16'hFFFF, 2'd3);
    end
    ordy = '1;
    rst  = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b, required 0", k, ir[k]);
      end
    end
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || pw[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_out[%0d]: out_valid=%b p=%h, required 0 0000", k, ov[k], pw[k]);
      end
    end
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_in_ready[%0d]: got %b, required 1", k, ir[k]);
      end
    end
    cycle();
  endtask

  task automatic test_single(string name, logic [15:0] x, logic [15:0] y, logic [15:0] z, logic [1:0] o, logic [15:0] want);
    idle();
    drive(0, x, y, z, o);
    #1;
    cycle();
    iv[0] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ov[0] !== (n == 1) || pw[0] !== ((n == 1) ? want : 16'h0000)) begin
        errors++;
        $display("FAIL %s n=%0d: out_valid=%b p=%h, required %b %h", name, n, ov[0], pw[0], (n == 1), (n == 1) ? want : 16'h0000);
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [$];
    int          when [$];
    logic [15:0] want [3] = '{16'h0F0F, 16'h00F0, 16'h000F};
    idle();
    for (int t = 0; t < 10; t++) begin
      case (t)
        0:       drive(0, 16'd3, 16'd5, 16'h0F00, 2'd1);
        1:       drive(0, 16'd3, 16'd5, 16'h00FF, 2'd2);
        2:       drive(0, 16'd3, 16'd5, 16'h1234, 2'd3);
        default: iv[0] = 1'b0;
      endcase
      #1;
      cycle();
      if (ov[0] === 1'b1) begin
        got.push_back(pw[0]);
        when.push_back(t);
      end
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i] || when[i] != i + 1) begin
          errors++;
          $display("FAIL b2b[%0d]: p=%h at t=%0d, required %h at t=%0d", i, got[i], when[i], want[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] want [$];
    logic [15:0] got [$];
    logic [15:0] held;
    int sent = 0, stall_left = 0, stall_seen = 0;
    bit stalled_once = 0;
    idle();
    for (int t = 0; t < 30; t++) begin
      ordy[1] = 1'b1;
      if (ov[1] && !stalled_once) begin
        stalled_once = 1;
        stall_left   = 3;
        held         = pw[1];
      end
      if (stall_left > 0) ordy[1] = 1'b0;
      if (sent < 4) drive(1, 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      else iv[1] = 1'b0;
      #1;
      checks++;
      if (ir[1] !== exp_ir(1)) begin
        errors++;
        $display("FAIL bp_in_ready t=%0d: got %b, required %b", t, ir[1], exp_ir(1));
      end
      if (stall_left > 0) begin
        stall_seen++;
        checks++;
        if (ir[1] !== 1'b0 || ov[1] !== 1'b1 || pw[1] !== held) begin
          errors++;
          $display("FAIL bp_stall t=%0d: in_ready=%b out_valid=%b p=%h, required 0 1 %h", t, ir[1], ov[1], pw[1], held);
        end
        stall_left--;
      end
      if (ov[1] && ordy[1]) got.push_back(pw[1]);
      if (iv[1] && ir[1]) begin
        want.push_back(ref_f(1, op_s[1], a_s[1], b_s[1], c_s[1]));
        sent++;
      end
      cycle();
      checks++;
      if (ov[1] !== exp_v(1) || pw[1] !== exp_p(1)) begin
        errors++;
        $display("FAIL bp_out t=%0d: out_valid=%b p=%h, required %b %h", t, ov[1], pw[1], exp_v(1), exp_p(1));
      end
    end
    checks++;
    if (stall_seen != 3 || got.size() != 4) begin
      errors++;
      $display("FAIL bp_totals: stall cycles %0d results %0d, required 3 and 4", stall_seen, got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h, required %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] got [$];
    logic [15:0] want;
    idle();
    drive(1, 16'h1111, 16'h0007, 16'hFFFF, 2'd0);
    #1;
    cycle();
    drive(1, 16'h2222, 16'h0003, 16'h0000, 2'd1);
    #1;
    cycle();
    iv[1] = 1'b0;
    rst   = 1'b1;
    #1;
    cycle();
    rst = 1'b0;
    checks++;
    if (ov[1] !== 1'b0 || pw[1] !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_out: out_valid=%b p=%h, required 0 0000", ov[1], pw[1]);
    end
    drive(1, 16'h0009, 16'h0009, 16'h00F0, 2'd2);
    want = 16'h0051 ^ 16'h00F0;
    #1;
    checks++;
    if (ir[1] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_accept: in_ready=%b, required 1", ir[1]);
    end
    cycle();
    iv[1] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (ov[1] === 1'b1) got.push_back(pw[1]);
      cycle();
    end
    checks++;
    if (got.size() != 1 || got[0] !== want) begin
      errors++;
      $display("FAIL midreset_results: count %0d first %h, required 1 result %h", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, want);
    end
  endtask

  task automatic test_depth1();
    logic [15:0] want [2] = '{16'h0000, 16'h00FF};
    logic [15:0] xa   [2] = '{16'h0010, 16'h000F};
    logic [15:0] xb   [2] = '{16'h0010, 16'h0011};
    idle();
    for (int i = 0; i < 2; i++) begin
      drive(2, xa[i], xb[i], 16'($urandom), 2'd3);
      #1;
      cycle();
      iv[2] = 1'b0;
      checks++;
      if (ov[2] !== 1'b1 || pw[2] !== want[i]) begin
        errors++;
        $display("FAIL depth1[%0d]: out_valid=%b p=%h, required 1 %h", i, ov[2], pw[2], want[i]);
      end
      cycle();
      checks++;
      if (ov[2] !== 1'b0 || pw[2] !== 16'h0000) begin
        errors++;
        $display("FAIL depth1_idle[%0d]: out_valid=%b p=%h, required 0 0000", i, ov[2], pw[2]);
      end
    end
  endtask

  task automatic test_random();
    idle();
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
        a_s[k]  = 16'($urandom);
        b_s[k]  = 16'($urandom);
        c_s[k]  = 16'($urandom);
        op_s[k] = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 63) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ir[k] !== exp_ir(k)) begin
          errors++;
          $display("FAIL rand_in_ready[%0d] t=%0d: got %b, required %b", k, t, ir[k], exp_ir(k));
        end
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_v(k) || pw[k] !== exp_p(k)) begin
          errors++;
          $display("FAIL rand_out[%0d] t=%0d: out_valid=%b p=%h, required %b %h", k, t, ov[k], pw[k], exp_v(k), exp_p(k));
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0; b_s[k] = '0; c_s[k] = '0; op_s[k] = '0;
    end
    test_reset();
    test_single("basic_and", 16'h0003, 16'h0005, 16'h00FF, 2'd0, 16'h000F);
    test_single("truncation", 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd0, 16'h0001);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_depth1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
